syscall_regfile: RTL and testbench

Parametrised integer register file for the single-cycle RISC-V core with a built-in ecall service unit. It generalises register count, data width and read-port count. Its I/O calls use ready/valid handshakes and stall the core instead of completing in one unconditional cycle. It sits between the decode stage (rs/rd indices, reg_write, ecall) and the board I/O wrapper (switch input, seven-segment output, LEDs).

---
 rtl/syscall_pkg.sv | 21 ++
 rtl/regfile_array.sv | 48 ++++
 rtl/syscall_regfile.sv | 156 +++++++++++++++
 tb/tb_syscall_regfile.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// Shared constants for the register file's ecall service unit: service codes,
// FSM states and status LED bit positions.
package syscall_pkg;

  localparam int SYS_PRINT = 1;
  localparam int SYS_READ  = 5;
  localparam int SYS_EXIT  = 10;
  localparam int SYS_TEST  = 11;

  localparam int LED_READ  = 7;
  localparam int LED_TEST  = 1;
  localparam int LED_HALT  = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_HALT
  } state_t;

endpackage

// File: rtl/regfile_array.sv
// Register storage with NUM_RD combinational read ports; x0 always reads zero
// and, when BYPASS is set, a normal write is forwarded to matching reads.
module regfile_array #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 0,
  parameter int A0_IDX = 10,
  parameter int A7_IDX = 17,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [XLEN-1:0]        i_wdata,
  input  logic                   i_byp_en,
  input  logic [NUM_RD*AW-1:0]   i_raddr,
  output logic [NUM_RD*XLEN-1:0] o_rdata,
  output logic [XLEN-1:0]        o_a0,
  output logic [XLEN-1:0]        o_a7
);

  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && i_waddr != '0) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_idx;
    logic          w_byp;
    assign w_idx = i_raddr[k*AW +: AW];
    assign w_byp = (BYPASS != 0) && i_byp_en && (w_idx == i_waddr);
    assign o_rdata[k*XLEN +: XLEN] = (w_idx == '0) ? '0 :
                                     w_byp         ? i_wdata :
                                                     r_regs[w_idx];
  end

  // Service decode and print see the stored values, never bypassed data.
  assign o_a0 = r_regs[A0_IDX];
  assign o_a7 = r_regs[A7_IDX];

endmodule

// File: rtl/syscall_regfile.sv
// Integer register file with an ecall service unit: print, read, exit and
// test-load services over ready/valid handshakes that stall the core.
module syscall_regfile
  import syscall_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int A0_IDX = 10,
  parameter int A7_IDX = 17,
  parameter int BYPASS = 0,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rs,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  input  logic [AW-1:0]          rd,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   reg_write,
  input  logic                   ecall,
  input  logic [XLEN-1:0]        test_case,
  input  logic [XLEN-1:0]        io_in_data,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  output logic [XLEN-1:0]        io_out_data,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic                   stall,
  output logic                   halted,
  output logic [7:0]             led_out
);

  state_t          r_state;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_data;
  logic            r_led_read;
  logic            r_led_test;
  logic            r_led_halt;
  logic            r_halted;

  logic [XLEN-1:0] w_a0;
  logic [XLEN-1:0] w_a7;
  logic            w_idle_ecall;
  logic            w_is_print;
  logic            w_is_read;
  logic            w_is_exit;
  logic            w_is_test;
  logic            w_norm_we;
  logic            w_test_we;
  logic            w_in_we;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [XLEN-1:0] w_wdata;

  assign w_idle_ecall = (r_state == S_IDLE) && ecall;
  assign w_is_print   = (w_a7 == XLEN'(SYS_PRINT));
  assign w_is_read    = (w_a7 == XLEN'(SYS_READ));
  assign w_is_exit    = (w_a7 == XLEN'(SYS_EXIT));
  assign w_is_test    = (w_a7 == XLEN'(SYS_TEST));

  // Write-port arbitration: only one source can be active in any state.
  assign w_norm_we = (r_state == S_IDLE) && !ecall && reg_write && (rd != '0);
  assign w_test_we = w_idle_ecall && w_is_test;
  assign w_in_we   = (r_state == S_WAIT_IN) && io_in_valid;
  assign w_we      = w_norm_we || w_test_we || w_in_we;
  assign w_waddr   = w_norm_we ? rd : AW'(A0_IDX);
  assign w_wdata   = w_norm_we ? wr_data : (w_test_we ? test_case : io_in_data);

  regfile_array #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NUM_RD(NUM_RD),
    .BYPASS(BYPASS),
    .A0_IDX(A0_IDX),
    .A7_IDX(A7_IDX)
  ) u_array (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_byp_en(w_norm_we),
    .i_raddr (rs),
    .o_rdata (rd_data),
    .o_a0    (w_a0),
    .o_a7    (w_a7)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_led_read  <= 1'b0;
      r_led_test  <= 1'b0;
      r_led_halt  <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_led_read <= 1'b0;
      r_led_test <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ecall) begin
            if (w_is_print) begin
              r_out_data  <= w_a0;
              r_out_valid <= 1'b1;
              r_state     <= S_WAIT_OUT;
            end else if (w_is_read) begin
              r_state <= S_WAIT_IN;
            end else if (w_is_exit) begin
              r_led_halt <= 1'b1;
              r_halted   <= 1'b1;
              r_state    <= S_HALT;
            end else if (w_is_test) begin
              r_led_test <= 1'b1;
            end
          end
        end
        S_WAIT_IN: begin
          if (io_in_valid) begin
            r_led_read <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        S_WAIT_OUT: begin
          if (io_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_HALT: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall drops in the handshake cycle so the held ecall retires with it.
  assign stall = (w_idle_ecall && (w_is_print || w_is_read)) ||
                 ((r_state == S_WAIT_IN)  && !io_in_valid)  ||
                 ((r_state == S_WAIT_OUT) && !io_out_ready) ||
                 (r_state == S_HALT);

  assign io_in_ready  = (r_state == S_WAIT_IN);
  assign io_out_valid = r_out_valid;
  assign io_out_data  = r_out_data;
  assign halted       = r_halted;

  always_comb begin
    led_out           = '0;
    led_out[LED_READ] = r_led_read;
    led_out[LED_TEST] = r_led_test;
    led_out[LED_HALT] = r_led_halt;
  end

endmodule

// File: tb/tb_syscall_regfile.sv
// Bench for syscall_regfile: directed service sequences checked against a
// behavioural register/service model every cycle, plus literal expectations.
module tb_syscall_regfile;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic                   clk;
  logic                   reset;
  logic [NUM_RD*AW-1:0]   rs;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [AW-1:0]          rd;
  logic [XLEN-1:0]        wr_data;
  logic                   reg_write;
  logic                   ecall;
  logic [XLEN-1:0]        test_case;
  logic [XLEN-1:0]        io_in_data;
  logic                   io_in_valid;
  logic                   io_in_ready;
  logic [XLEN-1:0]        io_out_data;
  logic                   io_out_valid;
  logic                   io_out_ready;
  logic                   stall;
  logic                   halted;
  logic [7:0]             led_out;

  syscall_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NUM_RD(NUM_RD),
    .A0_IDX(10),
    .A7_IDX(17),
    .BYPASS(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rs          (rs),
    .rd_data     (rd_data),
    .rd          (rd),
    .wr_data     (wr_data),
    .reg_write   (reg_write),
    .ecall       (ecall),
    .test_case   (test_case),
    .io_in_data  (io_in_data),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_out_data (io_out_data),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .stall       (stall),
    .halted      (halted),
    .led_out     (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents plus what the service unit is doing.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_wait_in, m_print, m_halt, m_led7, m_led1;
  logic [XLEN-1:0] m_out_data;

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_wait_in = 0; m_print = 0; m_halt = 0; m_led7 = 0; m_led1 = 0;
    m_out_data = '0;
  endtask

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] idx);
    bit idle;
    idle = !m_wait_in && !m_print && !m_halt;
    if (idx == 0) return '0;
    if (idle && !ecall && reg_write && rd != 0 && idx == rd) return wr_data;
    return m_regs[idx];
  endfunction

  function automatic logic exp_stall();
    if (m_halt)    return 1'b1;
    if (m_wait_in) return !io_in_valid;
    if (m_print)   return !io_out_ready;
    return ecall && (m_regs[17] == 1 || m_regs[17] == 5);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_clear();
    end else begin
      m_led7 = 0;
      m_led1 = 0;
      if (m_halt) begin
      end else if (m_wait_in) begin
        if (io_in_valid) begin
          m_regs[10] = io_in_data;
          m_led7 = 1;
          m_wait_in = 0;
        end
      end else if (m_print) begin
        if (io_out_ready) m_print = 0;
      end else if (ecall) begin
        case (m_regs[17])
          1:  begin m_out_data = m_regs[10]; m_print = 1; end
          5:  m_wait_in = 1;
          10: m_halt = 1;
          11: begin m_regs[10] = test_case; m_led1 = 1; end
          default: ;
        endcase
      end else if (reg_write && rd != 0) begin
        m_regs[rd] = wr_data;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < NUM_RD; k++)
        chk($sformatf("model rd_data[%0d]", k), rd_data[k*XLEN +: XLEN], exp_read(rs[k*AW +: AW]));
      chk("model stall", stall, exp_stall());
      chk("model io_in_ready", io_in_ready, m_wait_in);
      chk("model io_out_valid", io_out_valid, m_print);
      if (m_print) chk("model io_out_data", io_out_data, m_out_data);
      chk("model halted", halted, m_halt);
      chk("model led_out", led_out, {m_led7, 5'b0, m_led1, m_halt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] idx, input logic [XLEN-1:0] val);
    rd = idx; wr_data = val; reg_write = 1'b1; ecall = 1'b0;
    tick();
    reg_write = 1'b0;
  endtask

  int cnt;

  initial begin
    model_clear();
    reset = 1'b0; rs = '0; rd = '0; wr_data = '0; reg_write = 1'b0; ecall = 1'b0;
    test_case = '0; io_in_data = '0; io_in_valid = 1'b0; io_out_ready = 1'b0;
    tick();
    check_en = 1'b1;
    @(negedge clk); #2;
    chk("reset stall", stall, 1'b0);
    chk("reset io_in_ready", io_in_ready, 1'b0);
    chk("reset io_out_valid", io_out_valid, 1'b0);
    chk("reset io_out_data", io_out_data, 32'h0);
    chk("reset halted", halted, 1'b0);
    chk("reset led_out", led_out, 8'h00);
    @(negedge clk); reset = 1'b1;
    tick();

    // Normal writes, x0 drop, bypass
    wr(5'd5, 32'hDEADBEEF);
    wr(5'd0, 32'h1);
    rs = {5'd0, 5'd5};
    #1;
    chk("x5 read", rd_data[31:0], 32'hDEADBEEF);
    chk("x0 read", rd_data[63:32], 32'h0);
    rd = 5'd5; wr_data = 32'h11; reg_write = 1'b1;
    #1;
    chk("bypass read", rd_data[31:0], 32'h11);
    tick();
    reg_write = 1'b0;

    // Print service with back-pressure
    wr(5'd17, 32'd1);
    wr(5'd10, 32'd42);
    ecall = 1'b1; io_out_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (stall) cnt++;
      if (i > 0) chk("print data held", io_out_data, 32'd42);
      tick();
    end
    io_out_ready = 1'b1;
    @(negedge clk); #1;
    chk("print stall cycles", cnt, 4);
    chk("print handshake stall", stall, 1'b0);
    chk("print handshake data", io_out_data, 32'd42);
    tick();
    ecall = 1'b0; io_out_ready = 1'b0;
    #1;
    chk("print valid cleared", io_out_valid, 1'b0);

    // Read service, reg_write ignored while waiting
    wr(5'd17, 32'd5);
    ecall = 1'b1; rd = 5'd3; wr_data = 32'hBAD; reg_write = 1'b1;
    tick(); tick(); tick();
    io_in_valid = 1'b1; io_in_data = 32'h7;
    @(negedge clk); #1;
    chk("read handshake stall", stall, 1'b0);
    chk("read io_in_ready", io_in_ready, 1'b1);
    tick();
    ecall = 1'b0; io_in_valid = 1'b0; reg_write = 1'b0; rs = {5'd3, 5'd10};
    #1;
    chk("read a0", rd_data[31:0], 32'h7);
    chk("read x3 untouched", rd_data[63:32], 32'h0);
    chk("read led pulse", led_out, 8'h80);
    tick();
    chk("read led cleared", led_out, 8'h00);

    // Test-load service
    wr(5'd17, 32'd11);
    test_case = 32'h3; ecall = 1'b1;
    @(negedge clk); #1;
    chk("test stall", stall, 1'b0);
    tick();
    ecall = 1'b0;
    #1;
    chk("test a0", rd_data[31:0], 32'h3);
    chk("test led", led_out, 8'h02);
    tick();
    chk("test led cleared", led_out, 8'h00);

    // Exit service then random activity in HALT
    wr(5'd17, 32'd10);
    ecall = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      rs = NUM_RD*AW'($urandom); rd = AW'($urandom); wr_data = $urandom;
      reg_write = 1'($urandom); ecall = 1'($urandom); test_case = $urandom;
      io_in_data = $urandom; io_in_valid = 1'($urandom); io_out_ready = 1'($urandom);
      tick();
    end
    chk("halt halted", halted, 1'b1);
    chk("halt led", led_out, 8'h01);
    chk("halt stall", stall, 1'b1);
    reset = 1'b0;
    #1;
    chk("halt reset halted", halted, 1'b0);
    chk("halt reset led", led_out, 8'h00);
    rs = {5'd10, 5'd17};
    #1;
    chk("halt reset a0", rd_data[63:32], 32'h0);
    @(negedge clk);
    rd = '0; wr_data = '0; reg_write = 1'b0; ecall = 1'b0;
    io_in_valid = 1'b0; io_out_ready = 1'b0; reset = 1'b1;
    tick();

    // Reset during WAIT_OUT
    wr(5'd17, 32'd1);
    wr(5'd10, 32'h55);
    wr(5'd4, 32'h1234);
    ecall = 1'b1; io_out_ready = 1'b0;
    tick(); tick();
    chk("wait_out valid", io_out_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("async reset valid", io_out_valid, 1'b0);
    rs = {5'd4, 5'd17};
    #1;
    chk("async reset a7", rd_data[31:0], 32'h0);
    chk("async reset x4", rd_data[63:32], 32'h0);
    @(negedge clk);
    reset = 1'b1; ecall = 1'b0;
    tick();
    wr(5'd17, 32'd99);
    ecall = 1'b1;
    @(negedge clk); #1;
    chk("unknown code stall", stall, 1'b0);
    tick();
    ecall = 1'b0;
    #1;
    chk("unknown code led", led_out, 8'h00);
    chk("unknown code ready", io_in_ready, 1'b0);
    tick(); tick();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
